// File: rtl/os_sa_pkg.sv
// Shared constants for the output-stationary systolic array: sizing defaults,
// accumulator width derivation and the result-drain state encoding.
package os_sa_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_ROWS      = 8;
    localparam int DEF_FLUSH_CYC = 3;

    function automatic int acc_w(input int width);
        return 2 * width;
    endfunction

    localparam int DEF_ACC_W = acc_w(DEF_WIDTH);

    // Kept as plain 2-bit constants so older tooling downstream can consume them.
    typedef logic [1:0] drain_state_t;
    localparam drain_state_t ST_IDLE    = 2'd0;
    localparam drain_state_t ST_FLUSH   = 2'd1;
    localparam drain_state_t ST_CAPTURE = 2'd2;
    localparam drain_state_t ST_SEND    = 2'd3;

endpackage

// File: rtl/os_result_drain_if.sv
// Valid/ready result stream from the drain engine toward the output buffer.
interface os_result_drain_if
    import os_sa_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int IDX_W = 3
);

    logic [ACC_W-1:0] OUT_DATA;
    logic [IDX_W-1:0] OUT_IDX;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             OUT_LAST;

    modport master (
        output OUT_DATA,
        output OUT_IDX,
        output OUT_VALID,
        output OUT_LAST,
        input  OUT_READY
    );

    modport slave (
        input  OUT_DATA,
        input  OUT_IDX,
        input  OUT_VALID,
        input  OUT_LAST,
        output OUT_READY
    );

endinterface

// File: rtl/os_result_drain.sv
// Unloads one PE column: waits out the MAC pipeline, snapshots every accumulator,
// clears the PEs and streams the snapshot out one result per beat.
module os_result_drain
    import os_sa_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ROWS      = DEF_ROWS,
    parameter int FLUSH_CYC = DEF_FLUSH_CYC,
    localparam int ACC_W    = acc_w(WIDTH),
    localparam int IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [ROWS*ACC_W-1:0] MAC_IN,
    output logic                  ACC_CLR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR_OVERRUN,
    os_result_drain_if.master     out_if
);

    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = (FLUSH_CYC > 0) ? CNT_W'(FLUSH_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROWS - 1);

    drain_state_t          state;
    logic [CNT_W-1:0]      flush_cnt;
    logic [IDX_W-1:0]      idx;
    logic [ROWS*ACC_W-1:0] shadow;
    logic                  done_q;
    logic                  err_q;
    logic                  send_valid;
    logic                  handshake;
    logic                  last_row;

    assign send_valid = (state == ST_SEND);
    assign handshake  = send_valid & out_if.OUT_READY;
    assign last_row   = (idx == LAST_IDX);

    // START is only honoured from IDLE; the DONE cycle is already IDLE, so a
    // back-to-back tile starts cleanly there.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            idx       <= '0;
            shadow    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (START && (state != ST_IDLE)) begin
                err_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        if (FLUSH_CYC == 0) begin
                            state <= ST_CAPTURE;
                        end else begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_LOAD;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    shadow <= MAC_IN;
                    idx    <= '0;
                    state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (last_row) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stream outputs are forced to zero outside SEND so idle/reset shows a clean bus.
    assign out_if.OUT_VALID = send_valid;
    assign out_if.OUT_DATA  = send_valid ? shadow[int'(idx)*ACC_W +: ACC_W] : '0;
    assign out_if.OUT_IDX   = send_valid ? idx : '0;
    assign out_if.OUT_LAST  = send_valid & last_row;

    assign ACC_CLR     = (state == ST_CAPTURE);
    assign BUSY        = (state != ST_IDLE);
    assign DONE        = done_q;
    assign ERR_OVERRUN = err_q;

endmodule

// File: tb/tb_os_result_drain.sv
// Self-checking bench for os_result_drain: directed scenarios plus randomized
// tiles and backpressure against a cycle-timeline reference model.
module tb_os_result_drain;
    import os_sa_pkg::*;

    localparam int ROWS   = DEF_ROWS;
    localparam int ACC_W  = DEF_ACC_W;
    localparam int IDX_W  = $clog2(ROWS);
    localparam int FLUSH  = DEF_FLUSH_CYC;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  START;
    logic [ROWS*ACC_W-1:0] MAC_IN;
    logic                  ACC_CLR;
    logic                  BUSY;
    logic                  DONE;
    logic                  ERR_OVERRUN;

    int checks = 0;
    int errors = 0;
    bit errExp = 1'b0;

    os_result_drain_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) outBus ();

    os_result_drain dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .MAC_IN      (MAC_IN),
        .ACC_CLR     (ACC_CLR),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR_OVERRUN (ERR_OVERRUN),
        .out_if      (outBus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkIdle(input string tag, input bit doneExp);
        checkOutput({tag, "_valid"}, outBus.OUT_VALID, 1'b0);
        checkOutput({tag, "_data"},  outBus.OUT_DATA, '0);
        checkOutput({tag, "_idx"},   outBus.OUT_IDX, '0);
        checkOutput({tag, "_last"},  outBus.OUT_LAST, 1'b0);
        checkOutput({tag, "_clr"},   ACC_CLR, 1'b0);
        checkOutput({tag, "_busy"},  BUSY, 1'b0);
        checkOutput({tag, "_done"},  DONE, doneExp);
        checkOutput({tag, "_err"},   ERR_OVERRUN, errExp);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            stepCycle();
            checkIdle("idle", 1'b0);
        end
    endtask

    function automatic logic [ROWS*ACC_W-1:0] randTile();
        logic [ROWS*ACC_W-1:0] t;
        for (int i = 0; i < ROWS; i++) t[i*ACC_W +: ACC_W] = $urandom;
        return t;
    endfunction

    // One tile from START to the DONE cycle (or to a reset abort). Expected
    // beats are the rows of tileData in order; timing follows START at t,
    // ACC_CLR at t+FLUSH+1, first beat at t+FLUSH+2, DONE after the last accept.
    task automatic applyStimulus(input logic [ROWS*ACC_W-1:0] tileData, input int stallIdx,
                                 input int stallLen, input bit readyRandom, input int overrunAt,
                                 input bit scramble, input int abortIdx);
        int  expIdx;
        int  offset;
        int  stalled;
        int  budget;
        bit  ready;
        bit  startNow;
        logic [ACC_W-1:0] word;

        MAC_IN = tileData;
        START  = 1'b1;
        stepCycle();
        START = 1'b0;
        for (int k = 1; k <= FLUSH; k++) begin
            checkOutput("flush_busy", BUSY, 1'b1);
            checkOutput("flush_clr", ACC_CLR, 1'b0);
            checkOutput("flush_valid", outBus.OUT_VALID, 1'b0);
            checkOutput("flush_err", ERR_OVERRUN, errExp);
            stepCycle();
        end
        checkOutput("capture_clr", ACC_CLR, 1'b1);
        checkOutput("capture_busy", BUSY, 1'b1);
        checkOutput("capture_valid", outBus.OUT_VALID, 1'b0);
        stepCycle();
        MAC_IN = scramble ? '1 : randTile();

        expIdx  = 0;
        offset  = FLUSH + 2;
        stalled = 0;
        budget  = 0;
        while (expIdx < ROWS && budget < 200) begin
            if (expIdx == abortIdx) begin
                RST = 1'b1;
                stepCycle();
                RST    = 1'b0;
                errExp = 1'b0;
                checkIdle("reset_abort", 1'b0);
                return;
            end
            word = tileData[expIdx*ACC_W +: ACC_W];
            checkOutput("send_valid", outBus.OUT_VALID, 1'b1);
            checkOutput("send_idx", outBus.OUT_IDX, expIdx);
            checkOutput("send_data", outBus.OUT_DATA, word);
            checkOutput("send_last", outBus.OUT_LAST, (expIdx == ROWS - 1));
            checkOutput("send_done", DONE, 1'b0);
            checkOutput("send_busy", BUSY, 1'b1);
            checkOutput("send_clr", ACC_CLR, 1'b0);
            checkOutput("send_err", ERR_OVERRUN, errExp);
            if (expIdx == stallIdx && stalled < stallLen) begin
                ready = 1'b0;
                stalled++;
            end else if (readyRandom) begin
                ready = ($urandom_range(0, 2) != 0);
            end else begin
                ready = 1'b1;
            end
            startNow         = (offset == overrunAt);
            outBus.OUT_READY = ready;
            START            = startNow;
            stepCycle();
            START = 1'b0;
            offset++;
            budget++;
            if (startNow) errExp = 1'b1;
            if (ready) expIdx++;
        end
        checkOutput("send_budget", expIdx, ROWS);
        outBus.OUT_READY = $urandom_range(0, 1);
        checkOutput("done_pulse", DONE, 1'b1);
        checkOutput("done_busy", BUSY, 1'b0);
        checkOutput("done_valid", outBus.OUT_VALID, 1'b0);
        checkOutput("done_err", ERR_OVERRUN, errExp);
    endtask

    initial begin
        logic [ROWS*ACC_W-1:0] tile;

        RST              = 1'b1;
        START            = 1'b0;
        MAC_IN           = '0;
        outBus.OUT_READY = 1'b0;
        stepCycle();
        stepCycle();
        checkIdle("reset_held", 1'b0);
        RST = 1'b0;
        stepCycle();
        outBus.OUT_READY = 1'b1;
        checkIdle("reset", 1'b0);

        $display("[TB] basic drain");
        for (int i = 0; i < ROWS; i++) tile[i*ACC_W +: ACC_W] = ACC_W'(i + 1);
        applyStimulus(tile, -1, 0, 1'b0, -1, 1'b0, -1);
        idleCycles(2);

        $display("[TB] backpressure on row 2");
        tile = randTile();
        tile[2*ACC_W +: ACC_W] = 32'hDEAD_BEEF;
        applyStimulus(tile, 2, 3, 1'b0, -1, 1'b0, -1);
        idleCycles(1);

        $display("[TB] snapshot isolation");
        applyStimulus(randTile(), -1, 0, 1'b0, -1, 1'b1, -1);
        idleCycles(1);

        $display("[TB] back-to-back tiles");
        applyStimulus(randTile(), -1, 0, 1'b0, -1, 1'b0, -1);
        applyStimulus(randTile(), -1, 0, 1'b1, -1, 1'b0, -1);
        applyStimulus(randTile(), -1, 0, 1'b0, -1, 1'b0, -1);
        idleCycles(1);

        $display("[TB] randomized backpressure");
        for (int n = 0; n < 6; n++) begin
            applyStimulus(randTile(), $urandom_range(0, ROWS - 1), $urandom_range(0, 4),
                          1'b1, -1, 1'b0, -1);
            idleCycles($urandom_range(1, 3));
        end

        $display("[TB] reset mid-send");
        applyStimulus(randTile(), -1, 0, 1'b1, -1, 1'b0, 4);
        idleCycles(1);
        applyStimulus(randTile(), -1, 0, 1'b0, -1, 1'b0, -1);
        idleCycles(1);

        $display("[TB] overrun");
        applyStimulus(randTile(), -1, 0, 1'b0, FLUSH + 3, 1'b0, -1);
        idleCycles(3);
        applyStimulus(randTile(), -1, 0, 1'b1, -1, 1'b0, -1);
        idleCycles(1);

        RST = 1'b1;
        stepCycle();
        RST    = 1'b0;
        errExp = 1'b0;
        checkIdle("reset_clears_err", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
